// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that feeds one UART TX engine from NREQ
// requesters. A grant latches the winner's data and raises a start strobe,
// which is held until the engine clears it. A START timeout recovers a dead
// engine. A transaction ends when the engine drops busy.
module uart_tx_arb #(
  parameter int NREQ      = 3,
  parameter int DW        = 8,
  parameter int TO_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*DW-1:0] i_req_dat,
  output logic [NREQ-1:0]    o_req_ack,
  output logic [DW-1:0]      o_tx,
  output logic               o_tx_start,
  input  logic               i_tx_start_clear,
  input  logic               i_tx_busy,
  output logic [NREQ-1:0]    o_grant,
  output logic               o_busy,
  output logic               o_timeout_err,
  input  logic               i_err_clr,
  output logic [15:0]        o_sent_cnt
);

  localparam int         LGW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  // START lasts exactly TO_CYCLES cycles, counted from 0 on entry.
  localparam logic [9:0] TO_LAST = 10'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t          state, state_n;
  logic [LGW-1:0]  last_grant;
  logic [9:0]      to_cnt;

  logic [NREQ-1:0] rot;
  int              pick;
  int              win_int;
  logic [LGW-1:0]  win_idx;
  logic [NREQ-1:0] win_oh;
  logic [DW-1:0]   win_dat;

  logic            grant_go, clr_go, to_fire, done_go;

  // Round-robin pick: rotate requests so last_grant+1 sits at bit 0,
  // take the lowest set bit, then map back to an absolute index.
  always_comb begin
    rot  = NREQ'({i_req, i_req} >> (int'(last_grant) + 1));
    pick = 0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (rot[j]) pick = j;
    win_int = int'(last_grant) + 1 + pick;
    if (win_int >= NREQ) win_int = win_int - NREQ;
    win_idx = LGW'(win_int);
    win_oh  = NREQ'(1) << win_idx;
    win_dat = DW'(i_req_dat >> (DW * win_int));
  end

  // Next state and one-cycle event strobes.
  always_comb begin
    state_n  = state;
    grant_go = 1'b0;
    clr_go   = 1'b0;
    to_fire  = 1'b0;
    done_go  = 1'b0;
    case (state)
      IDLE: begin
        if (i_en && !i_tx_busy && (|i_req)) begin
          grant_go = 1'b1;
          state_n  = START;
        end
      end
      START: begin
        // A clear on the terminal-count cycle still counts as a clean handoff.
        if (i_tx_start_clear) begin
          clr_go  = 1'b1;
          state_n = WAIT;
        end else if (to_cnt == TO_LAST) begin
          to_fire = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (!i_tx_busy) begin
          done_go = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath: latched data, strobes, grant, timeout counter, status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tx          <= '0;
      o_tx_start    <= 1'b0;
      o_req_ack     <= '0;
      o_grant       <= '0;
      o_timeout_err <= 1'b0;
      o_sent_cnt    <= '0;
      to_cnt        <= '0;
      last_grant    <= LGW'(NREQ - 1);
    end else begin
      o_req_ack <= '0;
      if (grant_go) begin
        o_tx       <= win_dat;
        o_tx_start <= 1'b1;
        o_grant    <= win_oh;
        o_req_ack  <= win_oh;
        last_grant <= win_idx;
        to_cnt     <= '0;
      end
      if (state == START && !clr_go && !to_fire)
        to_cnt <= to_cnt + 10'd1;
      if (clr_go)
        o_tx_start <= 1'b0;
      if (to_fire) begin
        o_tx_start <= 1'b0;
        o_grant    <= '0;
      end
      if (done_go) begin
        o_grant    <= '0;
        o_sent_cnt <= o_sent_cnt + 16'd1;
      end
      // A fresh timeout beats a simultaneous clear request.
      if (to_fire)        o_timeout_err <= 1'b1;
      else if (i_err_clr) o_timeout_err <= 1'b0;
    end
  end

  assign o_busy = (state != IDLE);

endmodule
